// File: rtl/buft32_rslice_pkg.sv
// Shared defaults for the 32-bit register slice: datapath and delivered-beat counter widths.
// Pure declarations; no logic, no latency, no flow control.
package buft32_rslice_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 32;
endpackage

// File: rtl/buft32_rslice_if.sv
// One valid/ready channel; master drives valid/data, slave returns ready.
// Pure wiring: zero latency, backpressure is whatever ready says.
interface buft32_rslice_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic [DATA_WIDTH-1:0] data;
  logic                  ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/buft32_rslice.sv
// Skid register slice: 1-cycle latency when empty, holds up to 2 beats, s_ready/m_data straight from flops.
// Backpressure: s_ready drops only once two beats are held; flush drops held beats, beat_cnt counts deliveries.
module buft32_rslice
  import buft32_rslice_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int CNT_WIDTH  = CNT_W_DEF
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic                 flush,
  buft32_rslice_if.slave       s,
  buft32_rslice_if.master      m,
  output logic [1:0]           occ,
  output logic [CNT_WIDTH-1:0] beat_cnt
);
  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic                  s_ready_q;
  logic                  in_xfer, out_xfer;
  logic                  load_main, main_from_skid, load_skid;

  assign in_xfer  = s.valid & s_ready_q;
  assign m.valid  = (state_q != EMPTY);
  assign out_xfer = m.valid & m.ready;
  assign s.ready  = s_ready_q;
  assign m.data   = main_q;
  assign occ      = state_q;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_xfer && m.ready) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (m.ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (m.ready) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only clears validity; data registers keep whatever they hold.
    if (flush) begin
      state_d        = EMPTY;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
      beat_cnt  <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d != FULL);
      if (load_main) main_q <= main_from_skid ? skid_q : s.data;
      if (load_skid) skid_q <= s.data;
      if (out_xfer)  beat_cnt <= beat_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_buft32_rslice.sv
// Randomised and directed checks of the register slice against a queue model of held beats.
module tb_buft32_rslice;
  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        flush4;
  logic [1:0]  occ, occ4;
  logic [31:0] beat_cnt;
  logic [3:0]  beat_cnt4;

  buft32_rslice_if #(.DATA_WIDTH(32)) s_if ();
  buft32_rslice_if #(.DATA_WIDTH(32)) m_if ();
  buft32_rslice_if #(.DATA_WIDTH(32)) s4_if ();
  buft32_rslice_if #(.DATA_WIDTH(32)) m4_if ();

  always #5 clk_sys = ~clk_sys;

  buft32_rslice #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .flush(flush),
    .s(s_if), .m(m_if), .occ(occ), .beat_cnt(beat_cnt)
  );

  buft32_rslice #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk_sys(clk_sys), .rst_n(rst_n), .flush(flush4),
    .s(s4_if), .m(m4_if), .occ(occ4), .beat_cnt(beat_cnt4)
  );

  int total = 0;
  int bad   = 0;

  // Model: the ordered list of beats the slice currently holds.
  logic [31:0]     mq[$];
  logic            exp_rdy;
  longint unsigned exp_cnt;
  longint unsigned n_dlv;
  bit              last_acc;
  bit              chk_en;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_rdy = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] d, input logic r, input logic f);
    logic acc, dlv;
    acc = v & exp_rdy;
    dlv = r & (mq.size() > 0);
    if (dlv) begin
      void'(mq.pop_front());
      exp_cnt++;
      n_dlv++;
    end
    if (f) mq.delete();
    else if (acc) mq.push_back(d);
    exp_rdy  = (mq.size() < 2);
    last_acc = acc & !f;
  endtask

  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("s_ready", {63'd0, s_if.ready}, {63'd0, exp_rdy});
      chk("m_valid", {63'd0, m_if.valid}, {63'd0, mq.size() != 0});
      chk("occ", {62'd0, occ}, 64'(mq.size()));
      chk("beat_cnt", {32'd0, beat_cnt}, {32'd0, exp_cnt[31:0]});
      if (mq.size() != 0) chk("m_data", {32'd0, m_if.data}, {32'd0, mq[0]});
    end
  end

  // Drive one cycle of inputs, confirm s_ready ignores them, then advance the model on the edge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic r, input logic f);
    logic sr;
    sr = s_if.ready;
    s_if.valid = v;
    s_if.data  = d;
    m_if.ready = r;
    flush      = f;
    #1 chk("s_ready_no_comb_path", {63'd0, s_if.ready}, {63'd0, sr});
    @(posedge clk_sys);
    if (!rst_n) model_reset();
    else model_step(v, d, r, f);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          occ_max;
    logic        rdy_min;
    int          acc_n;
    int          cycles;
    logic [31:0] nxt;
    longint unsigned base;

    rst_n = 1'b0; flush = 1'b0; flush4 = 1'b0;
    s_if.valid = 1'b0; s_if.data = '0; m_if.ready = 1'b0;
    s4_if.valid = 1'b0; s4_if.data = '0; m4_if.ready = 1'b0;
    chk_en = 1'b0; n_dlv = 0; last_acc = 1'b0;
    model_reset();

    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_s_ready", {63'd0, s_if.ready}, 64'd0);
    chk("rst_m_valid", {63'd0, m_if.valid}, 64'd0);
    chk("rst_m_data", {32'd0, m_if.data}, 64'd0);
    chk("rst_occ", {62'd0, occ}, 64'd0);
    chk("rst_beat_cnt", {32'd0, beat_cnt}, 64'd0);
    chk("rst_beat_cnt4", {60'd0, beat_cnt4}, 64'd0);
    rst_n = 1'b1;
    #1 chk("s_ready_before_first_edge", {63'd0, s_if.ready}, 64'd0);
    chk_en = 1'b1;
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("s_ready_first_edge", {63'd0, s_if.ready}, 64'd1);

    // Streaming at full rate.
    occ_max = 0; rdy_min = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      cyc(1'b1, 32'(i), 1'b1, 1'b0);
      if (int'(occ) > occ_max) occ_max = int'(occ);
      if (!s_if.ready) rdy_min = 1'b0;
      if (i == 1) begin
        chk("first_beat_valid", {63'd0, m_if.valid}, 64'd1);
        chk("first_beat_data", {32'd0, m_if.data}, 64'd1);
      end
    end
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("stream_beat_cnt", {32'd0, beat_cnt}, 64'd100);
    chk("stream_occ_max", 64'(occ_max), 64'd1);
    chk("stream_s_ready_held", {63'd0, rdy_min}, 64'd1);

    // Fill, stall, drain.
    cyc(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
    cyc(1'b1, 32'hAAAA_0003, 1'b0, 1'b0);
    chk("full_occ", {62'd0, occ}, 64'd2);
    chk("full_s_ready", {63'd0, s_if.ready}, 64'd0);
    chk("full_head", {32'd0, m_if.data}, 64'hAAAA_0001);
    cyc(1'b1, 32'hAAAA_0003, 1'b1, 1'b0);
    chk("drain_second", {32'd0, m_if.data}, 64'hAAAA_0002);
    cyc(1'b1, 32'hAAAA_0003, 1'b1, 1'b0);
    chk("drain_third", {32'd0, m_if.data}, 64'hAAAA_0003);
    chk("drain_third_valid", {63'd0, m_if.valid}, 64'd1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("drain_empty", {63'd0, m_if.valid}, 64'd0);
    chk("drain_beat_cnt", {32'd0, beat_cnt}, 64'd103);

    // Flush from FULL.
    cyc(1'b1, 32'hBEEF_0001, 1'b0, 1'b0);
    cyc(1'b1, 32'hBEEF_0002, 1'b0, 1'b0);
    chk("flush_pre_occ", {62'd0, occ}, 64'd2);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("flush_m_valid", {63'd0, m_if.valid}, 64'd0);
    chk("flush_occ", {62'd0, occ}, 64'd0);
    chk("flush_s_ready", {63'd0, s_if.ready}, 64'd1);
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    chk("post_flush_occ", {62'd0, occ}, 64'd1);
    chk("post_flush_data", {32'd0, m_if.data}, 64'h1234_5678);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("post_flush_cnt", {32'd0, beat_cnt}, 64'd104);

    // Flush with both handshakes live: delivery counts, incoming beat is dropped.
    cyc(1'b1, 32'h55, 1'b0, 1'b0);
    cyc(1'b1, 32'h66, 1'b1, 1'b1);
    chk("flush_both_occ", {62'd0, occ}, 64'd0);
    chk("flush_both_cnt", {32'd0, beat_cnt}, 64'd105);

    // Random valid/ready, incrementing data.
    base = n_dlv; acc_n = 0; nxt = 32'd1; cycles = 0;
    while (acc_n < 10000 && cycles < 60000) begin
      cyc(1'($urandom_range(0, 1)), nxt, 1'($urandom_range(0, 1)), 1'b0);
      if (last_acc) begin
        acc_n++;
        nxt = nxt + 32'd1;
      end
      cycles++;
    end
    cycles = 0;
    while (mq.size() != 0 && cycles < 10) begin
      cyc(1'b0, 32'd0, 1'b1, 1'b0);
      cycles++;
    end
    chk("rand_accepted", 64'(acc_n), 64'd10000);
    chk("rand_delivered", n_dlv - base, 64'd10000);
    chk("rand_beat_cnt", {32'd0, beat_cnt}, 64'd10105);

    // Asynchronous reset while FULL.
    cyc(1'b1, 32'h77, 1'b0, 1'b0);
    cyc(1'b1, 32'h88, 1'b0, 1'b0);
    chk("pre_reset_occ", {62'd0, occ}, 64'd2);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_m_valid", {63'd0, m_if.valid}, 64'd0);
    chk("arst_s_ready", {63'd0, s_if.ready}, 64'd0);
    chk("arst_occ", {62'd0, occ}, 64'd0);
    chk("arst_beat_cnt", {32'd0, beat_cnt}, 64'd0);
    chk("arst_m_data", {32'd0, m_if.data}, 64'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
    cyc(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
    chk("cafe_data", {32'd0, m_if.data}, 64'hCAFE_F00D);
    chk("cafe_occ", {62'd0, occ}, 64'd1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("cafe_cnt", {32'd0, beat_cnt}, 64'd1);
    chk("cafe_done_occ", {62'd0, occ}, 64'd0);

    // Counter wrap on the 4-bit build: 17 deliveries end at 1.
    m4_if.ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      s4_if.valid = 1'b1;
      s4_if.data  = 32'(i);
      cyc(1'b0, 32'd0, 1'b0, 1'b0);
    end
    chk("wrap_cnt_16", {60'd0, beat_cnt4}, 64'd0);
    chk("wrap_head", {32'd0, m4_if.data}, 64'd17);
    s4_if.valid = 1'b0;
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("wrap_cnt_17", {60'd0, beat_cnt4}, 64'd1);
    chk("wrap_occ", {62'd0, occ4}, 64'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
